// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the MIPS core memory/I-O responder.
//   - FSM state encoding for mem_io_responder
//   - address map constants (RAM region nibble, GPIO register addresses)
//   - access-class type and the address decode helper
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACC_RAM      = 2'd0,
    ACC_GPIO_OUT = 2'd1,
    ACC_GPIO_IN  = 2'd2,
    ACC_BAD      = 2'd3
  } acc_e;

  localparam logic [3:0]  REGION_RAM    = 4'h0;
  localparam logic [31:0] GPIO_OUT_ADDR = 32'h1000_0000;
  localparam logic [31:0] GPIO_IN_ADDR  = 32'h1000_0004;

  // Misalignment wins over every region, so a misaligned access is never
  // performed anywhere. GPIO entries only decode when the GPIO block exists.
  function automatic acc_e decode_addr(input logic [31:0] a, input logic gpio_en);
    if (a[1:0] != 2'b00)                 return ACC_BAD;
    if (a[31:28] == REGION_RAM)          return ACC_RAM;
    if (gpio_en && (a == GPIO_OUT_ADDR)) return ACC_GPIO_OUT;
    if (gpio_en && (a == GPIO_IN_ADDR))  return ACC_GPIO_IN;
    return ACC_BAD;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_if: single shared instruction/data memory port of the multicycle core.
//   req/we/addr/wdata : initiator -> responder (req held until ready)
//   rdata/ready/err   : responder -> initiator (one-cycle completion pulse)
// Modports: master (core side), slave (responder side).
interface mem_io_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_io_responder_ram.sv
// mem_ram_1p: single-port synchronous word RAM with registered read.
//   clk   : rising-edge clock
//   we    : write enable (write at clock edge)
//   addr  : word index, DEPTH_LOG2 bits
//   wdata : write word
//   rdata : word read at the previous edge (read-before-write)
// Contents are not reset.
module mem_ram_1p #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: target side of the core's shared memory port.
// One word access at a time, WAIT_CYCLES wait states, word RAM plus
// optional GPIO registers (build with MEM_IO_GPIO_EN to include them).
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   bus      : mem_io_if.slave (req/we/addr/wdata in, rdata/ready/err out)
//   gpio_out : GPIO output register          (MEM_IO_GPIO_EN only)
//   gpio_in  : asynchronous GPIO input pins  (MEM_IO_GPIO_EN only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req; captures we/addr/wdata on acceptance
// WAIT    | counting down wait states
// RESP    | ready/err/rdata valid; write committed at end of this cycle
module mem_io_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int GPIO_W      = 8
) (
  input  logic           clk,
  input  logic           reset,
`ifdef MEM_IO_GPIO_EN
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
`endif
  mem_io_if.slave        bus
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_io_responder: WAIT_CYCLES out of range 0..15");
  end
  if (GPIO_W < 1 || GPIO_W > 32) begin : g_bad_gpio_w
    $error("mem_io_responder: GPIO_W out of range 1..32");
  end

`ifdef MEM_IO_GPIO_EN
  localparam logic GPIO_EN = 1'b1;
`else
  localparam logic GPIO_EN = 1'b0;
`endif

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ram_sel_q, ram_sel_d;

`ifdef MEM_IO_GPIO_EN
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_sync1_q, gpio_sync2_q;
`endif

  // In IDLE the live bus fields describe the transaction being accepted;
  // afterwards the captured copies do. Decode and RAM addressing both follow
  // this so a zero-wait access can read the RAM on its acceptance edge.
  logic        txn_we;
  logic [31:0] txn_addr;
  acc_e        acc;
  logic        enter_resp;
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign txn_we   = (state_q == ST_IDLE) ? bus.we   : we_q;
  assign txn_addr = (state_q == ST_IDLE) ? bus.addr : addr_q;
  assign acc      = decode_addr(txn_addr, GPIO_EN);
  assign ram_we   = (state_q == ST_RESP) && we_q && (acc == ACC_RAM);

  mem_ram_1p #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (txn_addr[DEPTH_LOG2+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    ram_sel_d  = 1'b0;
    enter_resp = 1'b0;
`ifdef MEM_IO_GPIO_EN
    gpio_out_d = gpio_out_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_CNT;
          if (WAIT_CNT == 4'd0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
`ifdef MEM_IO_GPIO_EN
        if (we_q && (acc == ACC_GPIO_OUT)) gpio_out_d = wdata_q[GPIO_W-1:0];
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Response fields are registered on the edge that enters RESP, so they
    // are nonzero only during the ready cycle.
    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = (acc == ACC_BAD) || ((acc == ACC_GPIO_IN) && txn_we);
      if (!txn_we) begin
        case (acc)
          ACC_RAM: ram_sel_d = 1'b1;
`ifdef MEM_IO_GPIO_EN
          ACC_GPIO_OUT: rdata_d = 32'(gpio_out_q);
          ACC_GPIO_IN:  rdata_d = 32'(gpio_sync2_q);
`endif
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      ram_sel_q    <= 1'b0;
`ifdef MEM_IO_GPIO_EN
      gpio_out_q   <= '0;
      gpio_sync1_q <= '0;
      gpio_sync2_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      ram_sel_q    <= ram_sel_d;
`ifdef MEM_IO_GPIO_EN
      gpio_out_q   <= gpio_out_d;
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
`endif
    end
  end

  // RAM read data comes straight from the RAM output register and is gated
  // by a flag that is only set during the RESP cycle of a RAM read.
  assign bus.rdata = ram_sel_q ? ram_rdata : rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
`ifdef MEM_IO_GPIO_EN
  assign gpio_out  = gpio_out_q;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: one instance with WAIT_CYCLES=1
// (main tests) and one with WAIT_CYCLES=0 (latency and back-to-back).
module tb_mem_io_responder;
  import mips_mem_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  mem_io_if bus1 ();
  mem_io_if bus0 ();

`ifdef MEM_IO_GPIO_EN
  logic [7:0] gpio_out1, gpio_in1, gpio_out0, gpio_in0;
`endif

  mem_io_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(1), .GPIO_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MEM_IO_GPIO_EN
    .gpio_out (gpio_out1),
    .gpio_in  (gpio_in1),
`endif
    .bus      (bus1.slave)
  );

  mem_io_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0), .GPIO_W(8)) dut0 (
    .clk      (clk),
    .reset    (reset),
`ifdef MEM_IO_GPIO_EN
    .gpio_out (gpio_out0),
    .gpio_in  (gpio_in0),
`endif
    .bus      (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Starts and ends on a negedge with the target in IDLE. lat counts
  // negedges from the acceptance edge to the first one that sees ready.
  task automatic access(input bit sel0, input logic we, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat);
    logic rdy;
    if (sel0) begin bus0.req = 1'b1; bus0.we = we; bus0.addr = a; bus0.wdata = d; end
    else      begin bus1.req = 1'b1; bus1.we = we; bus1.addr = a; bus1.wdata = d; end
    lat = 0;
    rdy = 1'b0;
    @(posedge clk);
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy = sel0 ? bus0.ready : bus1.ready;
    end
    rd = sel0 ? bus0.rdata : bus1.rdata;
    er = sel0 ? bus0.err : bus1.err;
    if (sel0) begin bus0.req = 1'b0; bus0.addr = 32'hFFFF_FFFF; bus0.wdata = '0; end
    else      begin bus1.req = 1'b0; bus1.addr = 32'hFFFF_FFFF; bus1.wdata = '0; end
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [5:0]  hist;
  logic [31:0] rd_a, rd_b;
  bit          seen_first;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
`ifdef MEM_IO_GPIO_EN
    gpio_in1 = 8'h00;
    gpio_in0 = 8'h00;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_ready", bus1.ready, 32'd0);
    check("rst_err",   bus1.err,   32'd0);
    check("rst_rdata", bus1.rdata, 32'd0);
    check("rst_state", dut.state_q, ST_IDLE);
`ifdef MEM_IO_GPIO_EN
    check("rst_gpio_out", gpio_out1, 32'd0);
`endif

    // Write then read RAM, WAIT_CYCLES=1
    access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
    check("wr10_lat", lat, 32'd2);
    check("wr10_err", er, 32'd0);
    access(0, 1'b0, 32'h0000_0010, '0, rd, er, lat);
    check("rd10_lat",   lat, 32'd2);
    check("rd10_rdata", rd, 32'hDEAD_BEEF);
    check("rd10_err",   er, 32'd0);
    check("post_rdata_zero", bus1.rdata, 32'd0);

    // Aliasing inside the RAM region (index is addr[9:2])
    access(0, 1'b0, 32'h0FFF_FC10, '0, rd, er, lat);
    check("alias_rdata", rd, 32'hDEAD_BEEF);
    check("alias_err",   er, 32'd0);

    // Misaligned write is not performed
    access(0, 1'b1, 32'h0000_0012, 32'h1234_5678, rd, er, lat);
    check("mis_wr_err", er, 32'd1);
    access(0, 1'b0, 32'h0000_0010, '0, rd, er, lat);
    check("mis_keep_rdata", rd, 32'hDEAD_BEEF);
    access(0, 1'b0, 32'h0000_0013, '0, rd, er, lat);
    check("mis_rd_rdata", rd, 32'd0);
    check("mis_rd_err",   er, 32'd1);

    // Unmapped
    access(0, 1'b0, 32'h2000_0000, '0, rd, er, lat);
    check("unm_rdata", rd, 32'd0);
    check("unm_err",   er, 32'd1);

`ifdef MEM_IO_GPIO_EN
    access(0, 1'b1, GPIO_OUT_ADDR, 32'hFFFF_FFA5, rd, er, lat);
    check("gpo_wr_err", er, 32'd0);
    check("gpo_pins",   gpio_out1, 32'h0000_00A5);
    access(0, 1'b0, GPIO_OUT_ADDR, '0, rd, er, lat);
    check("gpo_rd", rd, 32'h0000_00A5);
    gpio_in1 = 8'h3C;
    repeat (3) @(negedge clk);
    access(0, 1'b0, GPIO_IN_ADDR, '0, rd, er, lat);
    check("gpi_rd",     rd, 32'h0000_003C);
    check("gpi_rd_err", er, 32'd0);
    access(0, 1'b1, GPIO_IN_ADDR, 32'h0000_0055, rd, er, lat);
    check("gpi_wr_err", er, 32'd1);
    check("gpo_unchanged", gpio_out1, 32'h0000_00A5);
`else
    access(0, 1'b0, 32'h1000_0000, '0, rd, er, lat);
    check("nogpio_rd_rdata", rd, 32'd0);
    check("nogpio_rd_err",   er, 32'd1);
    access(0, 1'b1, 32'h1000_0004, 32'h0000_0055, rd, er, lat);
    check("nogpio_wr_err", er, 32'd1);
`endif

    // Reset during WAIT of a write aborts it
    access(0, 1'b1, 32'h0000_0020, 32'h1111_1111, rd, er, lat);
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 32'h0000_0020; bus1.wdata = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_wait", dut.state_q, ST_WAIT);
    reset = 1'b0;
    bus1.req = 1'b0;
    #1;
    check("abort_state", dut.state_q, ST_IDLE);
    @(negedge clk);
    check("abort_ready", bus1.ready, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready2", bus1.ready, 32'd0);
    access(0, 1'b0, 32'h0000_0020, '0, rd, er, lat);
    check("abort_old_data", rd, 32'h1111_1111);

    // WAIT_CYCLES=0 instance: latency and back-to-back reads with req held
    access(1, 1'b1, 32'h0000_0000, 32'hAAAA_0000, rd, er, lat);
    check("w0_wr_lat", lat, 32'd1);
    access(1, 1'b1, 32'h0000_0004, 32'h4444_4444, rd, er, lat);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h0000_0000;
    hist = '0;
    rd_a = '0;
    rd_b = '0;
    seen_first = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hist[i] = bus0.ready;
      if (bus0.ready) begin
        if (!seen_first) begin
          rd_a = bus0.rdata;
          bus0.addr = 32'h0000_0004;
          seen_first = 1'b1;
        end else begin
          rd_b = bus0.rdata;
          bus0.req = 1'b0;
        end
      end
    end
    bus0.req = 1'b0;
    check("b2b_pulses", hist, 32'b000101);
    check("b2b_rdata0", rd_a, 32'hAAAA_0000);
    check("b2b_rdata4", rd_b, 32'h4444_4444);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory and I/O responder for the multicycle MIPS core: the target side of the core's single shared instruction/data memory port. Accepts one word access at a time through a request/ready handshake, with programmable wait states. Serves a word-addressed RAM and, optionally, two memory-mapped GPIO registers. Sits between the datapath's address/write-data muxes and the instruction/data registers that the control FSM loads.

## Interface
- `DEPTH_LOG2`, default 8: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 1: wait states per access (0..15).
- `GPIO_W`, default 8: GPIO register width (1..32).
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `req` input, 1 bit: access request; held high by the initiator until `ready`.
- `we` input, 1 bit: 1 = write, 0 = read; sampled at acceptance.
- `addr` input, 32 bits: byte address; sampled at acceptance.
- `wdata` input, 32 bits: write data; sampled at acceptance.
- `rdata` output, 32 bits: read data; valid only while `ready`=1.
- `ready` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: one-cycle pulse coincident with `ready` for an illegal access.
- `gpio_out` output, GPIO_W bits: GPIO output register (only with the feature macro).
- `gpio_in` input, GPIO_W bits: asynchronous GPIO inputs (only with the feature macro).

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when `req`=1, capture `we`, `addr` and `wdata`, and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: decrement the counter. At 0, go to RESP.
  - RESP: drive `ready`=1, `rdata` and `err`. Commit any write in this cycle. Go to IDLE unconditionally.
- Captured values are used for the whole transaction. Changes to `addr`, `we` or `wdata` after acceptance are ignored.
- Address decode on the captured address:
  - `addr[31:28]`=0: RAM. Word index is `addr[DEPTH_LOG2+1:2]`; upper bits beyond the index are ignored, so the RAM aliases within the region.
  - 0x1000_0000: GPIO_OUT. Read/write; upper bits read as 0.
  - 0x1000_0004: GPIO_IN. Read-only; reads the synchronized value, zero-extended. A write is ignored and sets `err`.
  - Any other address: read returns 0, write is ignored, `err`=1.
- Misaligned access (`addr[1:0]`≠0) is never performed: no write, `rdata`=0, `err`=1.
- RAM contents are not reset. GPIO_OUT is reset to 0.
- `req` dropped before `ready` is a protocol violation; the transaction still completes.

## Timing
- Reset values: state IDLE, `ready`=0, `err`=0, `rdata`=0, `gpio_out`=0, wait counter 0.
- Latency: `ready` rises WAIT_CYCLES+1 cycles after the acceptance edge. With WAIT_CYCLES=0, `ready` is high the cycle after `req` is seen.
- Back-to-back: a `req` still high in the IDLE cycle after RESP starts a new access. Minimum issue interval is WAIT_CYCLES+2 cycles.
- `rdata` is registered and is 0 whenever `ready`=0.
- A write to RAM or GPIO_OUT takes effect at the end of the RESP cycle. A read of the same location in the next transaction returns the new value.
- GPIO_IN passes through a 2-flop synchronizer. A read reflects the pin value from at least 2 cycles before RESP.
- Reset mid-transaction aborts immediately: the write is not committed, `ready` stays 0 and the FSM returns to IDLE.

## Configuration
- `MEM_IO_GPIO_EN` defined: the GPIO ports, registers, synchronizer and decode entries exist.
- `MEM_IO_GPIO_EN` undefined:
  - `gpio_out` and `gpio_in` are removed.
  - Addresses 0x1000_0000 and 0x1000_0004 decode as unmapped: read 0, write ignored, `err`=1.

## Structure
- Shared package `mips_mem_pkg` holds:
  - the FSM state encoding;
  - the region and register constants: RAM region nibble 4'h0, GPIO_OUT_ADDR 32'h1000_0000, GPIO_IN_ADDR 32'h1000_0004.
- One sub-module, `mem_ram_1p`: single-port synchronous word RAM with registered read, parameterized by DEPTH_LOG2.
- FSM, decode, GPIO registers and synchronizer stay in the top module.

## Test plan
- Write then read RAM, WAIT_CYCLES=1:
  - write 0xDEADBEEF to 0x0000_0010 → `ready` 2 cycles after acceptance, `err`=0;
  - read 0x0000_0010 → `rdata`=0xDEADBEEF.
- WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with `req` held high → `ready` pulses 2 cycles apart, each for exactly 1 cycle.
- Misaligned write of 0x1234_5678 to 0x0000_0012 → `err`=1. A following read of 0x0000_0010 returns the old value.
- With `MEM_IO_GPIO_EN`:
  - write 0xA5 to 0x1000_0000 → `gpio_out`=0xA5 after RESP;
  - drive `gpio_in`=0x3C, read 0x1000_0004 → `rdata`=0x0000_003C;
  - write to 0x1000_0004 → `err`=1.
- Unmapped read of 0x2000_0000 → `rdata`=0, `err`=1. Without the macro, 0x1000_0000 behaves the same way.
- Assert `reset` during WAIT of a write to 0x0000_0020 → no `ready`, FSM in IDLE, and a subsequent read of 0x0000_0020 returns the prior contents.
